// File: rtl/riscv_pkg.sv
// Shared store-path definitions: store size encodings, size helpers and the
// store sequencer FSM state type.
package riscv_pkg;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_ctrl_t;

    localparam int SZ_BYTE = 1;
    localparam int SZ_HALF = 2;
    localparam int SZ_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } st_state_t;

    // Byte mask of an unshifted store; reserved codes fall back to a byte.
    function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
        case (ctrl)
            SH:      size_mask = 4'((1 << SZ_HALF) - 1);
            SW:      size_mask = 4'((1 << SZ_WORD) - 1);
            default: size_mask = 4'((1 << SZ_BYTE) - 1);
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane alignment: byte offset, size and data in; an
// 8-lane byte mask and 64-bit shifted data out, spanning two bus words.
module store_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_ctrl,
    input  logic [31:0] i_data,
    output logic [7:0]  o_mask8,
    output logic [63:0] o_data64,
    output logic        o_split
);

    logic [3:0]  w_mask4;
    logic [31:0] w_data_masked;

    always_comb begin
        w_mask4       = size_mask(i_ctrl);
        w_data_masked = i_data & {{8{w_mask4[3]}}, {8{w_mask4[2]}},
                                  {8{w_mask4[1]}}, {8{w_mask4[0]}}};
        o_mask8       = {4'b0000, w_mask4} << i_off;
        o_data64      = {32'd0, w_data_masked} << {i_off, 3'b000};
        // Any lane landing in the upper word means a second bus beat.
        o_split       = |o_mask8[7:4];
    end

endmodule

// File: rtl/store_seq_ctrl.sv
// Store-path sequencer: effective-address adder, per-beat registers and a
// request/grant FSM that issues one or two word-aligned memory beats.
module store_seq_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_base,
    input  logic [11:0]     st_imm,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      st_ctrl,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            st_done,
    output logic            st_split
);

    st_state_t       r_state;
    st_state_t       w_next_state;

    logic [XLEN-1:0] w_ea;
    logic [XLEN-1:0] w_b0_addr;
    logic [7:0]      w_mask8;
    logic [63:0]     w_data64;
    logic            w_split;
    logic            w_accept;

    logic [XLEN-1:0] r_b0_addr;
    logic [XLEN-1:0] r_b1_addr;
    logic [XLEN-1:0] r_b0_wdata;
    logic [XLEN-1:0] r_b1_wdata;
    logic [3:0]      r_b0_be;
    logic [3:0]      r_b1_be;
    logic            r_split;

    assign w_ea      = st_base + {{(XLEN-12){st_imm[11]}}, st_imm};
    assign w_b0_addr = {w_ea[XLEN-1:2], 2'b00};
    assign w_accept  = st_valid & st_ready;

    store_align u_align (
        .i_off    (w_ea[1:0]),
        .i_ctrl   (st_ctrl),
        .i_data   (st_data),
        .o_mask8  (w_mask8),
        .o_data64 (w_data64),
        .o_split  (w_split)
    );

    // Both beats are captured at acceptance so input changes cannot disturb
    // a store already on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b0_addr  <= '0;
            r_b1_addr  <= '0;
            r_b0_wdata <= '0;
            r_b1_wdata <= '0;
            r_b0_be    <= '0;
            r_b1_be    <= '0;
            r_split    <= 1'b0;
        end else if (w_accept) begin
            r_b0_addr  <= w_b0_addr;
            r_b1_addr  <= w_b0_addr + XLEN'(4);
            r_b0_wdata <= w_data64[31:0];
            r_b1_wdata <= w_data64[63:32];
            r_b0_be    <= w_mask8[3:0];
            r_b1_be    <= w_mask8[7:4];
            r_split    <= w_split;
        end
    end

    // NOTE: state lives in non-blocking assignments; the combinational blocks
    // below assign defaults first so no path leaves a latch behind.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (st_valid) w_next_state = ST_BEAT0;
            ST_BEAT0: if (mem_gnt)  w_next_state = r_split ? ST_BEAT1 : ST_DONE;
            ST_BEAT1: if (mem_gnt)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        st_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        st_done   = 1'b0;
        st_split  = 1'b0;
        case (r_state)
            ST_IDLE:  st_ready = ~rst;
            ST_BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = r_b0_addr;
                mem_wdata = r_b0_wdata;
                mem_be    = r_b0_be;
            end
            ST_BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = r_b1_addr;
                mem_wdata = r_b1_wdata;
                mem_be    = r_b1_be;
            end
            ST_DONE: begin
                st_done  = 1'b1;
                st_split = r_split;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Directed self-checking bench for store_seq_ctrl: aligned, sub-word,
// split-with-wrap, stalled-grant, reset-mid-split and reserved-code stores.
module tb_store_seq_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_base;
    logic [11:0] st_imm;
    logic [31:0] st_data;
    logic [2:0]  st_ctrl;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        st_done;
    logic        st_split;

    int n_checks = 0;
    int n_pass   = 0;

    store_seq_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_base   (st_base),
        .st_imm    (st_imm),
        .st_data   (st_data),
        .st_ctrl   (st_ctrl),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .st_done   (st_done),
        .st_split  (st_split)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic present(input logic [31:0] base, input logic [11:0] imm,
                           input logic [31:0] data, input logic [2:0] ctrl);
        st_valid = 1'b1;
        st_base  = base;
        st_imm   = imm;
        st_data  = data;
        st_ctrl  = ctrl;
    endtask

    // After the accepting edge, scramble the inputs to prove they were latched.
    task automatic scramble();
        st_valid = 1'b0;
        st_base  = 32'h5A5A_5A5A;
        st_imm   = 12'h7FF;
        st_data  = 32'hFFFF_FFFF;
        st_ctrl  = SW;
    endtask

    initial begin
        rst      = 1'b1;
        st_valid = 1'b0;
        st_base  = '0;
        st_imm   = '0;
        st_data  = '0;
        st_ctrl  = SB;
        mem_gnt  = 1'b0;

        // Reset state
        tick();
        check("rst_ready", 32'(st_ready), 32'd0);
        check("rst_req",   32'(mem_req),  32'd0);
        check("rst_addr",  mem_addr,      32'd0);
        check("rst_wdata", mem_wdata,     32'd0);
        check("rst_be",    32'(mem_be),   32'd0);
        check("rst_done",  32'(st_done),  32'd0);
        check("rst_split", 32'(st_split), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(st_ready), 32'd1);

        // Aligned SW, zero-wait grant
        mem_gnt = 1'b1;
        present(32'h0000_1000, 12'h004, 32'hDEAD_BEEF, SW);
        tick();
        scramble();
        check("sw_req",   32'(mem_req),  32'd1);
        check("sw_ready", 32'(st_ready), 32'd0);
        check("sw_addr",  mem_addr,      32'h0000_1004);
        check("sw_be",    32'(mem_be),   32'hF);
        check("sw_wdata", mem_wdata,     32'hDEAD_BEEF);
        tick();
        check("sw_done",  32'(st_done),  32'd1);
        check("sw_split", 32'(st_split), 32'd0);
        check("sw_req_off", 32'(mem_req), 32'd0);
        tick();
        check("sw_ready_again", 32'(st_ready), 32'd1);
        check("sw_done_pulse",  32'(st_done),  32'd0);

        // SB at byte offset 3
        present(32'h0000_2003, 12'h000, 32'h1234_56AB, SB);
        tick();
        scramble();
        check("sb_addr",  mem_addr,    32'h0000_2000);
        check("sb_be",    32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata,   32'hAB00_0000);
        tick();
        check("sb_done",  32'(st_done),  32'd1);
        check("sb_split", 32'(st_split), 32'd0);
        tick();

        // Split SW wrapping past the top of the address space
        present(32'hFFFF_FFFE, 12'h000, 32'hAABB_CCDD, SW);
        tick();
        scramble();
        check("split_b0_addr",  mem_addr,    32'hFFFF_FFFC);
        check("split_b0_be",    32'(mem_be), 32'hC);
        check("split_b0_wdata", mem_wdata,   32'hCCDD_0000);
        tick();
        check("split_b1_req",   32'(mem_req), 32'd1);
        check("split_b1_addr",  mem_addr,     32'h0000_0000);
        check("split_b1_be",    32'(mem_be),  32'h3);
        check("split_b1_wdata", mem_wdata,    32'h0000_AABB);
        check("split_b1_done",  32'(st_done), 32'd0);
        tick();
        check("split_done",  32'(st_done),  32'd1);
        check("split_flag",  32'(st_split), 32'd1);
        tick();
        check("split_ready", 32'(st_ready), 32'd1);

        // Negative immediate, SH, grant stalled three cycles
        mem_gnt = 1'b0;
        present(32'h0000_0100, 12'hFFE, 32'h0000_BEEF, SH);
        tick();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check("stall_req",   32'(mem_req),  32'd1);
            check("stall_addr",  mem_addr,      32'h0000_00FC);
            check("stall_be",    32'(mem_be),   32'hC);
            check("stall_wdata", mem_wdata,     32'hBEEF_0000);
            check("stall_done",  32'(st_done),  32'd0);
            if (i == 3) mem_gnt = 1'b1;
            tick();
        end
        check("stall_done_after_gnt", 32'(st_done),  32'd1);
        check("stall_split",          32'(st_split), 32'd0);
        tick();

        // Reset asserted during beat 1 of a split SH (offset 3)
        present(32'h0000_3003, 12'h000, 32'h0000_1234, SH);
        tick();
        scramble();
        check("rsplit_b0_be",    32'(mem_be), 32'h8);
        check("rsplit_b0_wdata", mem_wdata,   32'h3400_0000);
        tick();
        check("rsplit_b1_be",    32'(mem_be), 32'h1);
        check("rsplit_b1_wdata", mem_wdata,   32'h0000_0012);
        rst = 1'b1;
        tick();
        check("rsplit_req",   32'(mem_req),  32'd0);
        check("rsplit_done",  32'(st_done),  32'd0);
        check("rsplit_ready", 32'(st_ready), 32'd0);
        check("rsplit_addr",  mem_addr,      32'd0);
        rst = 1'b0;
        tick();
        check("rsplit_done_later", 32'(st_done),  32'd0);
        check("rsplit_ready_back", 32'(st_ready), 32'd1);

        // Reserved code 5 behaves as SB, offset 1
        present(32'h0000_5001, 12'h000, 32'hFFFF_FF77, 3'd5);
        tick();
        scramble();
        check("rsv_addr",  mem_addr,    32'h0000_5000);
        check("rsv_be",    32'(mem_be), 32'h2);
        check("rsv_wdata", mem_wdata,   32'h0000_7700);
        tick();
        check("rsv_done",  32'(st_done),  32'd1);
        check("rsv_split", 32'(st_split), 32'd0);
        tick();
        check("rsv_ready", 32'(st_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
